// File: rtl/proc_sched_pkg.sv
// Shared definitions for the frame scheduler and the processing block it feeds:
// scheduler states, register map, CTRL bit positions and datapath mode encodings.
package proc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_FRAME,
        ST_GAP
    } sched_state_t;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_CLR  = 2'd2;

    localparam int unsigned CTRL_GLOB_EN = 0;
    localparam int unsigned CTRL_S0_EN   = 1;
    localparam int unsigned CTRL_S1_EN   = 2;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_INVERT = 2'b01,
        MODE_CONV   = 2'b10,
        MODE_RSVD   = 2'b11
    } proc_mode_t;

    // A source programmed with the reserved mode is never granted.
    function automatic logic mode_usable(input logic [1:0] mode);
        return mode != MODE_RSVD;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the source not served last wins.
// Purely combinational; the caller owns the last-served register.
module rr_arbiter2 (
    input  logic [1:0] elig,
    input  logic       last_served,
    output logic       grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |elig;
        if (&elig) begin
            grant = ~last_served;
        end else begin
            grant = elig[1];
        end
    end

endmodule

// File: rtl/proc_frame_scheduler.sv
// Frame-granular scheduler sharing one pixel datapath between two 8-bit sources.
// Optional stall watchdog enabled by defining FRAME_TIMEOUT_EN.
import proc_sched_pkg::*;

module proc_frame_scheduler #(
    parameter int unsigned IMG_WIDTH      = 32,
    parameter int unsigned IMG_HEIGHT     = 32,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  s0_pixel,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [7:0]  s1_pixel,
    input  logic        s1_valid,
    output logic        s1_ready,
    output logic [7:0]  m_pixel,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        proc_start,
    output logic [1:0]  proc_mode,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [7:0]  cfg_wdata,
    output logic        cur_src,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        err_timeout
);

    localparam int unsigned FRAME_BEATS = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    sched_state_t     state, state_nxt;
    logic [2:0]       ctrl;
    logic [3:0]       mode_reg;
    logic [CNT_W-1:0] pix_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_served;
    logic [1:0]       elig;
    logic             grant, grant_valid;
    logic             sel_valid;
    logic [7:0]       sel_pixel;
    logic             beat, last_beat, abort;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata[7:4];

    assign elig[0] = ctrl[CTRL_S0_EN] & mode_usable(mode_reg[1:0]) & s0_valid;
    assign elig[1] = ctrl[CTRL_S1_EN] & mode_usable(mode_reg[3:2]) & s1_valid;

    rr_arbiter2 u_arb (
        .elig        (elig),
        .last_served (last_served),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign sel_valid  = cur_src ? s1_valid : s0_valid;
    assign sel_pixel  = cur_src ? s1_pixel : s0_pixel;
    assign beat       = m_valid & m_ready;
    assign last_beat  = beat && (pix_cnt == LAST_BEAT);
    assign frame_done = last_beat;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (ctrl[CTRL_GLOB_EN]) state_nxt = ST_ARB;
            ST_ARB: begin
                if (!ctrl[CTRL_GLOB_EN]) begin
                    state_nxt = ST_IDLE;
                end else if (grant_valid) begin
                    state_nxt = ST_FRAME;
                end
            end
            ST_FRAME: if (last_beat || abort) state_nxt = ST_GAP;
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = ctrl[CTRL_GLOB_EN] ? ST_ARB : ST_IDLE;
                end
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        m_valid    = 1'b0;
        m_pixel    = '0;
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        proc_start = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_FRAME: begin
                proc_start = 1'b1;
                busy       = 1'b1;
                m_valid    = sel_valid;
                m_pixel    = sel_pixel;
                s0_ready   = ~cur_src & m_ready;
                s1_ready   = cur_src & m_ready;
            end
            ST_GAP:   busy = 1'b1;
            default:  ;
        endcase
    end

    // Grant and mode are captured only in ARB, so cfg writes mid-frame reach the next frame.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ctrl        <= '0;
            mode_reg    <= '0;
            cur_src     <= 1'b0;
            proc_mode   <= '0;
            last_served <= 1'b1;
            pix_cnt     <= '0;
            gap_cnt     <= '0;
            frame_count <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_CTRL: ctrl     <= cfg_wdata[2:0];
                    ADDR_MODE: mode_reg <= cfg_wdata[3:0];
                    default:   ;
                endcase
            end
            if (state == ST_ARB && ctrl[CTRL_GLOB_EN] && grant_valid) begin
                cur_src     <= grant;
                proc_mode   <= grant ? mode_reg[3:2] : mode_reg[1:0];
                last_served <= grant;
            end
            if (state == ST_FRAME) begin
                if (last_beat || abort) begin
                    pix_cnt <= '0;
                end else if (beat) begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end
            if (last_beat) begin
                frame_count <= frame_count + 16'd1;
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] stall_cnt;

    assign abort = (state == ST_FRAME) && !beat && (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt   <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state != ST_FRAME || beat) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (abort) begin
                err_timeout <= 1'b1;
            end else if (cfg_we && cfg_addr == ADDR_CLR) begin
                err_timeout <= 1'b0;
            end
        end
    end
`else
    assign abort       = 1'b0;
    assign err_timeout = 1'b0;
`endif

endmodule
